// File: rtl/pipeline_ctrl.sv
// Pipeline control: boot/run/halt/step sequencing, load-use stall, redirect flush,
// ID-stage operand forwarding selects and saturating stall/flush statistics.
module pipeline_ctrl #(
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       addr_rs_id,
  input  logic [4:0]       addr_rt_id,
  input  logic             rs_used_id,
  input  logic             rt_used_id,
  input  logic             is_store_id,
  input  logic             redirect_id,
  input  logic [4:0]       regw_addr_exe,
  input  logic             wb_wen_exe,
  input  logic             mem_ren_exe,
  input  logic [4:0]       regw_addr_mem,
  input  logic             wb_wen_mem,
  input  logic             mem_ren_mem,
  input  logic             debug_en,
  input  logic             debug_step,
  output logic             if_rst,
  output logic             id_rst,
  output logic             exe_rst,
  output logic             mem_rst,
  output logic             wb_rst,
  output logic             if_en,
  output logic             id_en,
  output logic             exe_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic [1:0]       exe_fwd_a_ctrl,
  output logic [1:0]       exe_fwd_b_ctrl,
  output logic             mem_fwd_m,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2,
    StStep = 2'd3
  } state_e;

  localparam logic [1:0] FwdReg    = 2'd0;
  localparam logic [1:0] FwdExeAlu = 2'd1;
  localparam logic [1:0] FwdMemAlu = 2'd2;
  localparam logic [1:0] FwdMemDm  = 2'd3;

  localparam int unsigned BootW = (BOOT_CYCLES > 2) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BootW-1:0] BootOne = BootW'(1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [BootW-1:0] boot_cnt_q, boot_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             step_q;

  logic             step_rise;
  logic             boot_last;
  logic             active;
  logic             load_use;
  logic             flush;
  logic             store_data_bypass;
  logic [1:0]       fwd_a_raw;
  logic [1:0]       fwd_b_raw;

  // EXE result wins over MEM; a load still in EXE has no data yet, so it falls
  // through to the MEM check and the stall covers the gap.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] addr);
    logic [1:0] sel;
    sel = FwdReg;
    if (used && (addr != 5'd0)) begin
      if (wb_wen_exe && (regw_addr_exe == addr) && !mem_ren_exe) begin
        sel = FwdExeAlu;
      end else if (wb_wen_mem && (regw_addr_mem == addr)) begin
        sel = mem_ren_mem ? FwdMemDm : FwdMemAlu;
      end
    end
    return sel;
  endfunction

  assign fwd_a_raw = fwd_sel(rs_used_id, addr_rs_id);
  assign fwd_b_raw = fwd_sel(rt_used_id, addr_rt_id);

  // Store data (rt) is picked up later in MEM, so it never stalls.
  assign load_use = wb_wen_exe && mem_ren_exe && (regw_addr_exe != 5'd0) &&
                    ((rs_used_id && (addr_rs_id == regw_addr_exe)) ||
                     (rt_used_id && !is_store_id && (addr_rt_id == regw_addr_exe)));

  assign store_data_bypass = is_store_id && mem_ren_exe && wb_wen_exe &&
                             (addr_rt_id != 5'd0) && (regw_addr_exe == addr_rt_id);

  assign active    = (state_q == StRun) || (state_q == StStep);
  assign flush     = active && redirect_id && !load_use;
  assign step_rise = debug_step && !step_q;
  assign boot_last = (BOOT_CYCLES <= 1) || (32'(boot_cnt_q) >= (BOOT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    unique case (state_q)
      StBoot: begin
        boot_cnt_d = boot_cnt_q + BootOne;
        if (boot_last) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (debug_en) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        if (!debug_en) begin
          state_d = StRun;
        end else if (step_rise) begin
          state_d = StStep;
        end
      end
      StStep: begin
        state_d = debug_en ? StHalt : StRun;
      end
      default: state_d = StBoot;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (active && load_use && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (flush && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StBoot;
      boot_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      step_q      <= debug_step;
    end
  end

  always_comb begin
    if_rst         = 1'b0;
    id_rst         = 1'b0;
    exe_rst        = 1'b0;
    mem_rst        = 1'b0;
    wb_rst         = 1'b0;
    if_en          = 1'b0;
    id_en          = 1'b0;
    exe_en         = 1'b0;
    mem_en         = 1'b0;
    wb_en          = 1'b0;
    exe_fwd_a_ctrl = FwdReg;
    exe_fwd_b_ctrl = FwdReg;
    mem_fwd_m      = 1'b1;
    unique case (state_q)
      StBoot: begin
        if_rst  = 1'b1;
        id_rst  = 1'b1;
        exe_rst = 1'b1;
        mem_rst = 1'b1;
        wb_rst  = 1'b1;
      end
      StRun, StStep: begin
        if_en          = 1'b1;
        id_en          = 1'b1;
        exe_en         = 1'b1;
        mem_en         = 1'b1;
        wb_en          = 1'b1;
        exe_fwd_a_ctrl = fwd_a_raw;
        exe_fwd_b_ctrl = fwd_b_raw;
        mem_fwd_m      = !store_data_bypass;
        if (load_use) begin
          // Hold IF/ID, inject a bubble into EXE; a pending redirect waits.
          if_en   = 1'b0;
          id_en   = 1'b0;
          exe_rst = 1'b1;
        end else if (redirect_id) begin
          id_rst = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam int unsigned BootCycles = 4;
  localparam int unsigned CntW       = 4;
  localparam int          CntMax     = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      addr_rs_id, addr_rt_id, regw_addr_exe, regw_addr_mem;
  logic            rs_used_id, rt_used_id, is_store_id, redirect_id;
  logic            wb_wen_exe, mem_ren_exe, wb_wen_mem, mem_ren_mem;
  logic            debug_en, debug_step;
  logic            if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic            if_en, id_en, exe_en, mem_en, wb_en;
  logic [1:0]      exe_fwd_a_ctrl, exe_fwd_b_ctrl;
  logic            mem_fwd_m;
  logic [1:0]      state;
  logic [CntW-1:0] stall_cnt, flush_cnt;
  logic [4:0]      rsts, ens;

  assign rsts = {if_rst, id_rst, exe_rst, mem_rst, wb_rst};
  assign ens  = {if_en, id_en, exe_en, mem_en, wb_en};

  pipeline_ctrl #(.BOOT_CYCLES(BootCycles), .CNT_W(CntW)) dut (
    .clk(clk), .rst(rst),
    .addr_rs_id(addr_rs_id), .addr_rt_id(addr_rt_id),
    .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
    .is_store_id(is_store_id), .redirect_id(redirect_id),
    .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe), .mem_ren_exe(mem_ren_exe),
    .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem), .mem_ren_mem(mem_ren_mem),
    .debug_en(debug_en), .debug_step(debug_step),
    .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
    .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
    .exe_fwd_a_ctrl(exe_fwd_a_ctrl), .exe_fwd_b_ctrl(exe_fwd_b_ctrl),
    .mem_fwd_m(mem_fwd_m), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 BOOT, 1 RUN, 2 HALT, 3 STEP
  int m_state = 0;
  int m_boot  = 0;
  bit m_step_q = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  function automatic int ref_fwd(input bit used, input int addr);
    if (!used || addr == 0) return 0;
    if (wb_wen_exe && int'(regw_addr_exe) == addr && !mem_ren_exe) return 1;
    if (wb_wen_mem && int'(regw_addr_mem) == addr) return mem_ren_mem ? 3 : 2;
    return 0;
  endfunction

  function automatic bit ref_stall();
    if (!(wb_wen_exe && mem_ren_exe) || regw_addr_exe == 5'd0) return 1'b0;
    return (rs_used_id && addr_rs_id == regw_addr_exe) ||
           (rt_used_id && !is_store_id && addr_rt_id == regw_addr_exe);
  endfunction

  function automatic bit ref_mem_fwd_m();
    return !(is_store_id && mem_ren_exe && wb_wen_exe &&
             addr_rt_id != 5'd0 && regw_addr_exe == addr_rt_id);
  endfunction

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_advance();
    bit act;
    if (rst) begin
      m_state = 0; m_boot = 0; m_step_q = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      act = (m_state == 1) || (m_state == 3);
      if (act && ref_stall() && m_stall < CntMax) m_stall++;
      if (act && redirect_id && !ref_stall() && m_flush < CntMax) m_flush++;
      case (m_state)
        0: begin
          m_boot++;
          if (m_boot >= int'(BootCycles)) m_state = 1;
        end
        1: if (debug_en) m_state = 2;
        2: if (!debug_en) m_state = 1; else if (debug_step && !m_step_q) m_state = 3;
        default: m_state = debug_en ? 2 : 1;
      endcase
      m_step_q = debug_step;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 1'b0; addr_rs_id = 5'd0; addr_rt_id = 5'd0; rs_used_id = 1'b0; rt_used_id = 1'b0;
    is_store_id = 1'b0; redirect_id = 1'b0; regw_addr_exe = 5'd0; wb_wen_exe = 1'b0;
    mem_ren_exe = 1'b0; regw_addr_mem = 5'd0; wb_wen_mem = 1'b0; mem_ren_mem = 1'b0;
    debug_en = 1'b0; debug_step = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    regw_addr_exe = r; wb_wen_exe = 1'b1; mem_ren_exe = 1'b1;
    rs_used_id = 1'b1; addr_rs_id = r;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    model_advance();
    rst = 1'b0;
    set_load_use(5'd2);
    redirect_id = 1'b1;
    for (int i = 0; i < int'(BootCycles); i++) begin
      @(negedge clk);
      n_checks++;
      if (rsts !== 5'h1f || ens !== 5'h00 || state !== 2'd0) begin
        n_fail++;
        $display("FAIL boot_ctrl[%0d]: rst=%b en=%b state=%0d, want rst=11111 en=00000 state=0",
                 i, rsts, ens, state);
      end
      n_checks++;
      if (exe_fwd_a_ctrl !== 2'd0 || exe_fwd_b_ctrl !== 2'd0 || mem_fwd_m !== 1'b1 ||
          stall_cnt !== '0 || flush_cnt !== '0) begin
        n_fail++;
        $display("FAIL boot_misc[%0d]: fa=%0d fb=%0d m=%b sc=%0d fc=%0d, want 0 0 1 0 0",
                 i, exe_fwd_a_ctrl, exe_fwd_b_ctrl, mem_fwd_m, stall_cnt, flush_cnt);
      end
      model_advance();
    end
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (state !== 2'd1 || ens !== 5'h1f || rsts !== 5'h00) begin
      n_fail++;
      $display("FAIL boot_exit: state=%0d en=%b rst=%b, want 1 11111 00000", state, ens, rsts);
    end
    model_advance();
  endtask

  task automatic test_load_use();
    int sc0;
    sc0 = m_stall;
    clear_inputs();
    set_load_use(5'd5);
    @(negedge clk);
    n_checks++;
    if (ens !== 5'b00111 || rsts !== 5'b00100) begin
      n_fail++;
      $display("FAIL load_use_stall: en=%b rst=%b, want 00111 00100", ens, rsts);
    end
    model_advance();
    clear_inputs();
    rs_used_id = 1'b1; addr_rs_id = 5'd5;
    regw_addr_mem = 5'd5; wb_wen_mem = 1'b1; mem_ren_mem = 1'b1;
    @(negedge clk);
    n_checks++;
    if (exe_fwd_a_ctrl !== 2'd3 || ens !== 5'h1f || rsts !== 5'h00) begin
      n_fail++;
      $display("FAIL load_use_fwd: fa=%0d en=%b rst=%b, want 3 11111 00000",
               exe_fwd_a_ctrl, ens, rsts);
    end
    n_checks++;
    if (stall_cnt !== CntW'(sc0 + 1)) begin
      n_fail++;
      $display("FAIL load_use_cnt: stall_cnt=%0d, want %0d", stall_cnt, sc0 + 1);
    end
    model_advance();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    regw_addr_exe = 5'd3; wb_wen_exe = 1'b1;
    regw_addr_mem = 5'd3; wb_wen_mem = 1'b1;
    rt_used_id = 1'b1; addr_rt_id = 5'd3;
    rs_used_id = 1'b1; addr_rs_id = 5'd9;
    @(negedge clk);
    n_checks++;
    if (exe_fwd_b_ctrl !== 2'd1 || exe_fwd_a_ctrl !== 2'd0) begin
      n_fail++;
      $display("FAIL fwd_exe_prio: fb=%0d fa=%0d, want 1 0", exe_fwd_b_ctrl, exe_fwd_a_ctrl);
    end
    model_advance();
    wb_wen_exe = 1'b0;
    @(negedge clk);
    n_checks++;
    if (exe_fwd_b_ctrl !== 2'd2) begin
      n_fail++;
      $display("FAIL fwd_mem_alu: fb=%0d, want 2", exe_fwd_b_ctrl);
    end
    model_advance();
    addr_rt_id = 5'd0; regw_addr_mem = 5'd0;
    @(negedge clk);
    n_checks++;
    if (exe_fwd_b_ctrl !== 2'd0) begin
      n_fail++;
      $display("FAIL fwd_r0: fb=%0d, want 0", exe_fwd_b_ctrl);
    end
    model_advance();
  endtask

  task automatic test_flush();
    int fc0, sc0;
    fc0 = m_flush;
    clear_inputs();
    redirect_id = 1'b1;
    @(negedge clk);
    n_checks++;
    if (id_rst !== 1'b1 || if_en !== 1'b1 || exe_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ctrl: id_rst=%b if_en=%b exe_rst=%b, want 1 1 0",
               id_rst, if_en, exe_rst);
    end
    model_advance();
    sc0 = m_stall;
    set_load_use(5'd6);
    @(negedge clk);
    n_checks++;
    if (flush_cnt !== CntW'(fc0 + 1)) begin
      n_fail++;
      $display("FAIL flush_cnt: flush_cnt=%0d, want %0d", flush_cnt, fc0 + 1);
    end
    n_checks++;
    if (id_rst !== 1'b0 || exe_rst !== 1'b1 || if_en !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_over_flush: id_rst=%b exe_rst=%b if_en=%b, want 0 1 0",
               id_rst, exe_rst, if_en);
    end
    model_advance();
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (flush_cnt !== CntW'(fc0 + 1) || stall_cnt !== CntW'(sc0 + 1)) begin
      n_fail++;
      $display("FAIL stall_over_flush_cnt: fc=%0d sc=%0d, want %0d %0d",
               flush_cnt, stall_cnt, fc0 + 1, sc0 + 1);
    end
    model_advance();
  endtask

  task automatic test_store();
    clear_inputs();
    is_store_id = 1'b1; rt_used_id = 1'b1; addr_rt_id = 5'd7;
    regw_addr_exe = 5'd7; wb_wen_exe = 1'b1; mem_ren_exe = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ens !== 5'h1f || exe_rst !== 1'b0 || mem_fwd_m !== 1'b0) begin
      n_fail++;
      $display("FAIL store_bypass: en=%b exe_rst=%b m=%b, want 11111 0 0", ens, exe_rst, mem_fwd_m);
    end
    model_advance();
    mem_ren_exe = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_fwd_m !== 1'b1 || exe_fwd_b_ctrl !== 2'd1) begin
      n_fail++;
      $display("FAIL store_alu: m=%b fb=%0d, want 1 1", mem_fwd_m, exe_fwd_b_ctrl);
    end
    model_advance();
  endtask

  task automatic test_debug();
    int steps, sc0;
    clear_inputs();
    debug_en = 1'b1;
    model_advance();
    sc0 = m_stall;
    set_load_use(5'd4);
    redirect_id = 1'b1;
    @(negedge clk);
    n_checks++;
    if (state !== 2'd2 || ens !== 5'h00 || rsts !== 5'h00) begin
      n_fail++;
      $display("FAIL halt_ctrl: state=%0d en=%b rst=%b, want 2 00000 00000", state, ens, rsts);
    end
    model_advance();
    clear_inputs();
    debug_en = 1'b1;
    debug_step = 1'b1;
    steps = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (state === 2'd3) begin
        steps++;
        n_checks++;
        if (ens !== 5'h1f) begin
          n_fail++;
          $display("FAIL step_en: en=%b, want 11111", ens);
        end
      end
      model_advance();
    end
    n_checks++;
    if (steps != 1) begin
      n_fail++;
      $display("FAIL step_once: step cycles=%0d, want 1", steps);
    end
    n_checks++;
    if (stall_cnt !== CntW'(sc0) || state !== 2'd2) begin
      n_fail++;
      $display("FAIL halt_hold: sc=%0d state=%0d, want %0d 2", stall_cnt, state, sc0);
    end
    debug_step = 1'b0;
    debug_en = 1'b0;
    model_advance();
    @(negedge clk);
    n_checks++;
    if (state !== 2'd1) begin
      n_fail++;
      $display("FAIL halt_release: state=%0d, want 1", state);
    end
    debug_en = 1'b1;
    model_advance();
    debug_step = 1'b1;
    model_advance();
    debug_en = 1'b0;
    debug_step = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state !== 2'd3) begin
      n_fail++;
      $display("FAIL step_enter: state=%0d, want 3", state);
    end
    model_advance();
    @(negedge clk);
    n_checks++;
    if (state !== 2'd1) begin
      n_fail++;
      $display("FAIL step_to_run: state=%0d, want 1", state);
    end
    model_advance();
  endtask

  task automatic test_saturation();
    clear_inputs();
    set_load_use(5'd8);
    for (int i = 0; i < CntMax + 5; i++) model_advance();
    clear_inputs();
    redirect_id = 1'b1;
    for (int i = 0; i < CntMax + 5; i++) model_advance();
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== CntW'(CntMax) || flush_cnt !== CntW'(CntMax)) begin
      n_fail++;
      $display("FAIL cnt_saturate: sc=%0d fc=%0d, want %0d %0d",
               stall_cnt, flush_cnt, CntMax, CntMax);
    end
    model_advance();
  endtask

  task automatic test_mid_reset();
    clear_inputs();
    set_load_use(5'd9);
    rst = 1'b1;
    model_advance();
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (state !== 2'd0 || stall_cnt !== '0 || flush_cnt !== '0 || rsts !== 5'h1f) begin
      n_fail++;
      $display("FAIL mid_reset: state=%0d sc=%0d fc=%0d rst=%b, want 0 0 0 11111",
               state, stall_cnt, flush_cnt, rsts);
    end
    for (int i = 0; i < int'(BootCycles); i++) model_advance();
  endtask

  task automatic test_random();
    logic [4:0] er, ee;
    bit dbg;
    dbg = 1'b0;
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 79) == 0);
      addr_rs_id    = 5'($urandom_range(0, 3));
      addr_rt_id    = 5'($urandom_range(0, 3));
      regw_addr_exe = 5'($urandom_range(0, 3));
      regw_addr_mem = 5'($urandom_range(0, 3));
      rs_used_id    = 1'($urandom_range(0, 1));
      rt_used_id    = 1'($urandom_range(0, 1));
      is_store_id   = 1'($urandom_range(0, 1));
      redirect_id   = ($urandom_range(0, 3) == 0);
      wb_wen_exe    = 1'($urandom_range(0, 1));
      mem_ren_exe   = 1'($urandom_range(0, 1));
      wb_wen_mem    = 1'($urandom_range(0, 1));
      mem_ren_mem   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0) dbg = !dbg;
      debug_en      = dbg;
      debug_step    = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      er = 5'h00;
      ee = 5'h00;
      if (m_state == 0) begin
        er = 5'h1f;
      end else if (m_state != 2) begin
        ee = 5'h1f;
        if (ref_stall()) begin
          ee[4] = 1'b0; ee[3] = 1'b0; er[2] = 1'b1;
        end else if (redirect_id) begin
          er[3] = 1'b1;
        end
      end
      n_checks++;
      if (state !== 2'(m_state) || rsts !== er || ens !== ee) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: state=%0d rst=%b en=%b, want %0d %b %b",
                 i, state, rsts, ens, m_state, er, ee);
      end
      n_checks++;
      if (stall_cnt !== CntW'(m_stall) || flush_cnt !== CntW'(m_flush)) begin
        n_fail++;
        $display("FAIL rand_cnt[%0d]: sc=%0d fc=%0d, want %0d %0d",
                 i, stall_cnt, flush_cnt, m_stall, m_flush);
      end
      if (m_state != 2) begin
        n_checks++;
        if (m_state == 0) begin
          if (exe_fwd_a_ctrl !== 2'd0 || exe_fwd_b_ctrl !== 2'd0 || mem_fwd_m !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_boot_fwd[%0d]: fa=%0d fb=%0d m=%b, want 0 0 1",
                     i, exe_fwd_a_ctrl, exe_fwd_b_ctrl, mem_fwd_m);
          end
        end else if (exe_fwd_a_ctrl !== 2'(ref_fwd(rs_used_id, int'(addr_rs_id))) ||
                     exe_fwd_b_ctrl !== 2'(ref_fwd(rt_used_id, int'(addr_rt_id))) ||
                     mem_fwd_m !== ref_mem_fwd_m()) begin
          n_fail++;
          $display("FAIL rand_fwd[%0d]: fa=%0d fb=%0d m=%b, want %0d %0d %b", i,
                   exe_fwd_a_ctrl, exe_fwd_b_ctrl, mem_fwd_m,
                   ref_fwd(rs_used_id, int'(addr_rs_id)), ref_fwd(rt_used_id, int'(addr_rt_id)),
                   ref_mem_fwd_m());
        end
      end
      model_advance();
    end
  endtask

  initial begin
    clear_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_forwarding();
    test_flush();
    test_store();
    test_debug();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter BOOT_CYCLES, default 4, number of cycles all stages are held in reset after rst deasserts.
REQ-002 Parameter CNT_W, default 16, width of the stall and flush statistics counters.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  main clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 addr_rs_id, addr_rt_id  in  5 each  source register addresses of the instruction in ID.
REQ-007 rs_used_id, rt_used_id  in  1 each  instruction in ID reads rs / rt, including ID-stage branch compare.
REQ-008 is_store_id  in  1  instruction in ID is a store; rt is store data only.
REQ-009 redirect_id  in  1  ID instruction changes PC (pc_src_ctrl != PC_NEXT and the branch is taken).
REQ-010 regw_addr_exe, wb_wen_exe, mem_ren_exe  in  5/1/1  destination, write enable and load flag of the EXE instruction.
REQ-011 regw_addr_mem, wb_wen_mem, mem_ren_mem  in  5/1/1  same fields for the MEM instruction.
REQ-012 debug_en  in  1  level; high requests halt.
REQ-013 debug_step  in  1  single-step request, acted on at its rising edge.
REQ-014 if_rst, id_rst, exe_rst, mem_rst, wb_rst  out  1 each  stage resets.
REQ-015 if_en, id_en, exe_en, mem_en, wb_en  out  1 each  stage enables.
REQ-016 exe_fwd_a_ctrl, exe_fwd_b_ctrl  out  2 each  ID operand source: 0 FROM_REG, 1 FROM_EXE_ALUOUT, 2 FROM_MEM_ALUOUT, 3 FROM_MEM_DM.
REQ-017 mem_fwd_m  out  1  1 = store data from data_rt_mem; 0 = store data from regw_data_wb.
REQ-018 state  out  2  0 BOOT, 1 RUN, 2 HALT, 3 STEP.
REQ-019 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-020 FSM: BOOT -> RUN after BOOT_CYCLES cycles; RUN -> HALT when debug_en=1; HALT -> STEP on a debug_step rising edge; STEP -> HALT after exactly one cycle, or -> RUN if debug_en=0; HALT -> RUN when debug_en=0.
REQ-021 BOOT: all *_rst=1, all *_en=0; the boot counter loads 0 on rst and increments once per BOOT cycle.
REQ-022 HALT: all *_rst=0, all *_en=0, so the pipeline is frozen; hazard logic has no effect.
REQ-023 RUN and STEP: all *_en=1 and all *_rst=0, except as modified by REQ-026 and REQ-027.
REQ-024 Forward A, per source: if rs_used_id=0 or addr_rs_id=0 -> 0. Else if wb_wen_exe and regw_addr_exe==addr_rs_id and !mem_ren_exe -> 1. Else if wb_wen_mem and regw_addr_mem==addr_rs_id -> (mem_ren_mem ? 3 : 2). Else -> 0. The EXE match has priority.
REQ-025 Forward B: the same rule using rt_used_id and addr_rt_id. When is_store_id=1, rt is excluded from the stall check; it is still forwarded.
REQ-026 Load-use stall: condition is wb_wen_exe, mem_ren_exe, regw_addr_exe!=0, and regw_addr_exe matching a used rs, or a used rt of a non-store. On stall: if_en=0, id_en=0, exe_rst=1 (bubble); MEM and WB advance.
REQ-027 Flush: redirect_id=1 with no stall -> id_rst=1, killing the fetched slot; if_en=1 so PC takes the target.
REQ-028 A stall overrides a simultaneous redirect: no flush that cycle; redirect is re-evaluated next cycle.
REQ-029 mem_fwd_m=0 iff is_store_id, mem_ren_exe, wb_wen_exe, and regw_addr_exe==addr_rt_id!=0; otherwise 1.
REQ-030 mem_fwd_m is sampled by the datapath with the ID->EXE transfer.
REQ-031 Stage controls and forwarding selects are combinational from the current state and inputs (same-cycle effect); state, counters and the debug_step delay register are registered.
REQ-032 stall_cnt +1 per RUN/STEP cycle with a stall; flush_cnt +1 per cycle with REQ-027 active; both hold at all-ones (no wrap).
REQ-033 The debug_step edge is detected against a registered copy; a held debug_step yields one STEP only. A step edge in RUN or BOOT is ignored.

Reset
REQ-034 rst=1 at any cycle, including mid-stall or in STEP: next state BOOT, boot counter 0, stall_cnt=flush_cnt=0, step register 0.
REQ-035 While in BOOT, outputs are: all *_rst=1, all *_en=0, fwd selects 0, mem_fwd_m=1, state=0.

Verification
REQ-036 rst 1 cycle, BOOT_CYCLES=4 -> *_rst high exactly 4 cycles after release, then state=1 and all en=1.
REQ-037 EXE: lw to r5 (mem_ren_exe=1); ID uses rs=r5 -> if_en=id_en=0, exe_rst=1 for 1 cycle; next cycle (load in MEM) exe_fwd_a_ctrl=3; stall_cnt=1.
REQ-038 EXE: add to r3; MEM: add to r3; ID rt=r3 used -> exe_fwd_b_ctrl=1; with EXE wb_wen=0 -> 2; addr_rt_id=0 -> 0.
REQ-039 redirect_id=1 with no hazard -> id_rst=1, if_en=1, flush_cnt=1. Same cycle with a load-use stall -> id_rst=0, flush_cnt unchanged.
REQ-040 sw with rt=r7 in ID, lw to r7 in EXE -> no stall, mem_fwd_m=0; EXE not a load -> mem_fwd_m=1.
REQ-041 debug_en=1 -> HALT, all en=0. debug_step held high 5 cycles -> exactly one STEP cycle. debug_en=0 -> RUN.
